// File: rtl/fix_msg_if.sv
// Field-in / byte-out bundle for the FIX message serializer.
// slave is the serializer's view; master is the field source plus byte sink.
interface fix_msg_if #(
  parameter int TAG_BYTES = 4,
  parameter int VAL_BYTES = 32
);
  localparam int TL = $clog2(TAG_BYTES + 1);
  localparam int VL = $clog2(VAL_BYTES + 1);

  logic                   field_valid_i;
  logic                   field_ready_o;
  logic [8*TAG_BYTES-1:0] tag_i;
  logic [TL-1:0]          tag_len_i;
  logic [8*VAL_BYTES-1:0] val_i;
  logic [VL-1:0]          val_len_i;
  logic                   last_i;
  logic [7:0]             data_o;
  logic                   data_valid_o;
  logic                   data_ready_i;
  logic                   sof_o;
  logic                   eom_o;
  logic [7:0]             chksum_o;
  logic                   err_o;

  modport slave (
    input  field_valid_i, tag_i, tag_len_i, val_i, val_len_i, last_i, data_ready_i,
    output field_ready_o, data_o, data_valid_o, sof_o, eom_o, chksum_o, err_o
  );

  modport master (
    output field_valid_i, tag_i, tag_len_i, val_i, val_len_i, last_i, data_ready_i,
    input  field_ready_o, data_o, data_valid_o, sof_o, eom_o, chksum_o, err_o
  );
endinterface

// File: rtl/fix_msg_serializer.sv
// Serializes tag/value fields as "tag=value<SOH>" bytes and, on the last field,
// appends the "10=ddd<SOH>" checksum trailer.
// state | meaning
// IDLE  | ready for a field       TAG/EQ/VAL/FSOH | field bytes, summed
// T1/T0/TEQ | trailer "10="      D2/D1/D0 | checksum digits   TSOH | final SOH
module fix_msg_serializer #(
  parameter int         TAG_BYTES = 4,
  parameter int         VAL_BYTES = 32,
  parameter logic [7:0] SOH       = 8'h01
) (
  input logic      clk,
  input logic      rst,
  fix_msg_if.slave bus
);
  localparam int TL = $clog2(TAG_BYTES + 1);
  localparam int VL = $clog2(VAL_BYTES + 1);
  localparam int IW = (TL > VL) ? TL : VL;

  localparam logic [3:0] S_IDLE = 4'd0,  S_TAG = 4'd1,  S_EQ  = 4'd2,  S_VAL  = 4'd3,
                         S_FSOH = 4'd4,  S_T1  = 4'd5,  S_T0  = 4'd6,  S_TEQ  = 4'd7,
                         S_D2   = 4'd8,  S_D1  = 4'd9,  S_D0  = 4'd10, S_TSOH = 4'd11;

  logic [3:0]             state, st_nx;
  logic [IW-1:0]          idx, idx_nx, idx_d;
  logic [8*TAG_BYTES-1:0] tag_q;
  logic [8*VAL_BYTES-1:0] val_q;
  logic [TL-1:0]          tlen_q;
  logic [VL-1:0]          vlen_q;
  logic                   last_q, in_msg;
  logic [7:0]             acc, ck;
  logic [7:0]             data_q, byte_nx, tag_byte, val_byte, d2, d1, d0;
  logic                   valid_q, sof_q, eom_q, ready_q, err_q;
  logic                   vld_nx, eom_nx, xfer, accept, legal, sum_state;

  assign xfer      = valid_q && bus.data_ready_i;
  assign accept    = ready_q && bus.field_valid_i;
  assign legal     = (bus.tag_len_i != '0) && (bus.tag_len_i <= TL'(TAG_BYTES)) &&
                     (bus.val_len_i <= VL'(VAL_BYTES));
  assign idx_nx    = idx + 1'b1;
  assign sum_state = (state == S_TAG) || (state == S_EQ) || (state == S_VAL) || (state == S_FSOH);
  assign d2        = 8'h30 + ck / 8'd100;
  assign d1        = 8'h30 + (ck / 8'd10) % 8'd10;
  assign d0        = 8'h30 + ck % 8'd10;

  always_comb begin
    tag_byte = '0;
    val_byte = '0;
    for (int k = 0; k < TAG_BYTES; k++)
      if (idx_nx == IW'(k)) tag_byte = tag_q[8*k +: 8];
    for (int k = 0; k < VAL_BYTES; k++)
      if (idx_nx == IW'(k)) val_byte = val_q[8*k +: 8];
  end

  always_comb begin
    st_nx   = S_IDLE;
    idx_d   = idx_nx;
    byte_nx = 8'h00;
    vld_nx  = 1'b1;
    eom_nx  = 1'b0;
    case (state)
      S_TAG:
        if (idx_nx < IW'(tlen_q)) begin st_nx = S_TAG; byte_nx = tag_byte; end
        else begin st_nx = S_EQ; byte_nx = 8'h3D; end
      S_EQ:
        if (vlen_q != '0) begin st_nx = S_VAL; idx_d = '0; byte_nx = val_q[7:0]; end
        else begin st_nx = S_FSOH; byte_nx = SOH; end
      S_VAL:
        if (idx_nx < IW'(vlen_q)) begin st_nx = S_VAL; byte_nx = val_byte; end
        else begin st_nx = S_FSOH; byte_nx = SOH; end
      S_FSOH:
        if (last_q) begin st_nx = S_T1; byte_nx = 8'h31; end
        else vld_nx = 1'b0;
      S_T1:    begin st_nx = S_T0;   byte_nx = 8'h30; end
      S_T0:    begin st_nx = S_TEQ;  byte_nx = 8'h3D; end
      S_TEQ:   begin st_nx = S_D2;   byte_nx = d2; end
      S_D2:    begin st_nx = S_D1;   byte_nx = d1; end
      S_D1:    begin st_nx = S_D0;   byte_nx = d0; end
      S_D0:    begin st_nx = S_TSOH; byte_nx = SOH; eom_nx = 1'b1; end
      default: vld_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      in_msg  <= 1'b0;
      acc     <= '0;
      ck      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eom_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (accept) begin
        if (legal) begin
          state   <= S_TAG;
          idx     <= '0;
          data_q  <= bus.tag_i[7:0];
          valid_q <= 1'b1;
          sof_q   <= !in_msg;
          eom_q   <= 1'b0;
          in_msg  <= 1'b1;
          ready_q <= 1'b0;
        end
      end else if (xfer) begin
        state   <= st_nx;
        idx     <= idx_d;
        data_q  <= byte_nx;
        valid_q <= vld_nx;
        sof_q   <= 1'b0;
        eom_q   <= eom_nx;
        ready_q <= (st_nx == S_IDLE);
        if (sum_state) acc <= acc + data_q;
        // ck includes the field SOH being transferred right now
        if (state == S_FSOH && last_q) ck <= acc + data_q;
        if (state == S_TSOH) begin
          acc    <= '0;
          in_msg <= 1'b0;
        end
      end else if (state == S_IDLE) begin
        ready_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && legal) begin
      tag_q  <= bus.tag_i;
      val_q  <= bus.val_i;
      tlen_q <= bus.tag_len_i;
      vlen_q <= bus.val_len_i;
      last_q <= bus.last_i;
    end
  end

  assign bus.field_ready_o = ready_q;
  assign bus.data_o        = data_q;
  assign bus.data_valid_o  = valid_q;
  assign bus.sof_o         = sof_q;
  assign bus.eom_o         = eom_q;
  assign bus.chksum_o      = ck;
  assign bus.err_o         = err_q;
endmodule

// File: tb/tb_fix_msg_serializer.sv
// Randomized bench for fix_msg_serializer against a byte-queue message model.
module tb_fix_msg_serializer;
  localparam int TB = 4;
  localparam int VB = 32;
  localparam int TL = $clog2(TB + 1);
  localparam int VL = $clog2(VB + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fix_msg_if #(.TAG_BYTES(TB), .VAL_BYTES(VB)) bus();
  fix_msg_serializer #(.TAG_BYTES(TB), .VAL_BYTES(VB), .SOH(8'h01)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // expected byte stream with per-byte flags
  logic [7:0] q_data[$];
  bit         q_sof[$];
  bit         q_eom[$];
  bit         q_end[$];
  logic [7:0] q_ck[$];
  int         m_sum = 0;
  bit         m_in_msg = 0;

  task automatic model_field(input logic [31:0] tag, input int tlen, input logic [255:0] val,
                             input int vlen, input bit last);
    logic [7:0] b[$];
    int         ck;
    for (int k = 0; k < tlen; k++) b.push_back(tag[8*k +: 8]);
    b.push_back(8'h3D);
    for (int k = 0; k < vlen; k++) b.push_back(val[8*k +: 8]);
    b.push_back(8'h01);
    for (int i = 0; i < b.size(); i++) begin
      q_data.push_back(b[i]);
      q_sof.push_back(i == 0 && !m_in_msg);
      q_eom.push_back(1'b0);
      q_end.push_back(i == b.size() - 1 && !last);
      q_ck.push_back(8'h00);
      m_sum += b[i];
    end
    m_in_msg = 1;
    if (last) begin
      ck = m_sum % 256;
      b = {8'h31, 8'h30, 8'h3D, 8'(8'h30 + ck / 100), 8'(8'h30 + (ck / 10) % 10),
           8'(8'h30 + ck % 10), 8'h01};
      for (int i = 0; i < 7; i++) begin
        q_data.push_back(b[i]);
        q_sof.push_back(1'b0);
        q_eom.push_back(i == 6);
        q_end.push_back(i == 6);
        q_ck.push_back(8'(ck));
      end
      m_sum = 0;
      m_in_msg = 0;
    end
  endtask

  task automatic model_reset();
    q_data.delete(); q_sof.delete(); q_eom.delete(); q_end.delete(); q_ck.delete();
    m_sum = 0;
    m_in_msg = 0;
  endtask

  int bp_mode = 0;
  int bp_i = 0;
  initial begin
    bus.data_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       bus.data_ready_i = 1'b1;
        1:       begin bus.data_ready_i = (bp_i % 3 == 0); bp_i++; end
        default: bus.data_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  bit         mon_en = 0;
  bit         prev_stall = 0;
  bit         rdy_chk = 0;
  logic [7:0] p_data, p_ck;
  logic       p_sof, p_eom;
  int         stalls = 0;
  int         vcnt = 0;
  logic [7:0] last_ck = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rdy_chk) begin
        chk_eq("rdy_after_field", bus.field_ready_o, 1);
        rdy_chk = 0;
      end
      if (bus.data_valid_o) begin
        vcnt++;
        chk_eq("rdy_low_busy", bus.field_ready_o, 0);
      end
      if (prev_stall) begin
        chk_eq("hold_valid", bus.data_valid_o, 1);
        chk_eq("hold_data", bus.data_o, p_data);
        chk_eq("hold_sof", bus.sof_o, p_sof);
        chk_eq("hold_eom", bus.eom_o, p_eom);
        chk_eq("hold_ck", bus.chksum_o, p_ck);
      end
      prev_stall = bus.data_valid_o && !bus.data_ready_i;
      if (prev_stall) begin
        stalls++;
        p_data = bus.data_o; p_sof = bus.sof_o; p_eom = bus.eom_o; p_ck = bus.chksum_o;
      end
      if (bus.data_valid_o && bus.data_ready_i) begin
        if (q_data.size() == 0) begin
          chk_eq("spurious_byte", bus.data_o, 32'hFFFF_FFFF);
        end else begin
          chk_eq("data", bus.data_o, q_data.pop_front());
          chk_eq("sof", bus.sof_o, q_sof.pop_front());
          chk_eq("eom", bus.eom_o, q_eom[0]);
          if (q_eom.pop_front()) begin
            chk_eq("chksum", bus.chksum_o, q_ck[0]);
            last_ck = bus.chksum_o;
          end
          void'(q_ck.pop_front());
          if (q_end.pop_front()) rdy_chk = 1;
        end
      end
    end else begin
      prev_stall = 0;
      rdy_chk = 0;
    end
  end

  task automatic send_field(input logic [31:0] tag, input int tlen, input logic [255:0] val,
                            input int vlen, input bit last);
    int n = 0;
    bit legal;
    legal = (tlen >= 1) && (tlen <= TB) && (vlen <= VB);
    while (!bus.field_ready_o && n < 3000) begin @(negedge clk); n++; end
    chk_eq("ready_wait", n < 3000, 1);
    bus.tag_i         = tag;
    bus.tag_len_i     = TL'(tlen);
    bus.val_i         = val;
    bus.val_len_i     = VL'(vlen);
    bus.last_i        = last;
    bus.field_valid_i = 1'b1;
    @(posedge clk);
    if (legal) model_field(tag, tlen, val, vlen, last);
    #1;
    bus.field_valid_i = 1'b0;
    @(negedge clk);
    chk_eq("err_pulse", bus.err_o, !legal);
    chk_eq("first_byte_valid", bus.data_valid_o, legal);
    if (!legal) begin
      @(negedge clk);
      chk_eq("err_one_cycle", bus.err_o, 0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_data.size() != 0 || !bus.field_ready_o) && n < 5000) begin @(negedge clk); n++; end
    chk_eq("drain", n < 5000, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_ready"}, bus.field_ready_o, 0);
    chk_eq({tag, "_valid"}, bus.data_valid_o, 0);
    chk_eq({tag, "_data"},  bus.data_o, 0);
    chk_eq({tag, "_sof"},   bus.sof_o, 0);
    chk_eq({tag, "_eom"},   bus.eom_o, 0);
    chk_eq({tag, "_ck"},    bus.chksum_o, 0);
    chk_eq({tag, "_err"},   bus.err_o, 0);
  endtask

  initial begin
    logic [31:0]  rtag;
    logic [255:0] rval;
    int           tl, vl;
    bit           lst;
    rst = 1'b0;
    bus.field_valid_i = 1'b0;
    bus.tag_i = '0; bus.tag_len_i = '0; bus.val_i = '0; bus.val_len_i = '0; bus.last_i = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b1;
    mon_en = 1;
    @(negedge clk);
    chk_eq("ready_after_reset", bus.field_ready_o, 1);

    // single last field "35"="A"
    vcnt = 0;
    send_field(32'h3533, 2, 256'h41, 1, 1);
    wait_drain();
    chk_eq("s1_ck", last_ck, 8'hE7);
    chk_eq("s1_cycles", vcnt, 12);

    // checksum wrap
    send_field(32'h31, 1, 256'h7A7A7A7A, 4, 1);
    wait_drain();
    chk_eq("wrap_ck", last_ck, 8'h57);

    // backpressure 1,0,0,...
    bp_i = 0; bp_mode = 1;
    @(negedge clk);
    vcnt = 0; stalls = 0;
    send_field(32'h3533, 2, 256'h41, 1, 1);
    wait_drain();
    chk_eq("bp_ck", last_ck, 8'hE7);
    chk_eq("bp_cycles", vcnt, 12 + stalls);
    bp_mode = 0;
    @(negedge clk);

    // two fields in one message
    send_field(32'h3934, 2, 256'h4241, 2, 0);
    send_field(32'h3535, 2, 256'h58, 1, 1);
    wait_drain();
    chk_eq("two_field_ck", last_ck, 8'h2E);

    // illegal fields, then a legal last field
    send_field(32'h31, 0, 256'h0, 0, 1);
    send_field(32'h31, 1, 256'h0, VB + 1, 1);
    send_field(32'h31, 1, 256'h7A7A7A7A, 4, 1);
    wait_drain();
    chk_eq("after_illegal_ck", last_ck, 8'h57);

    // reset during a 10-byte value
    send_field(32'h39, 1, 256'h6A696867666564636261, 10, 1);
    repeat (3) @(negedge clk);
    mon_en = 0;
    rst = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b1;
    mon_en = 1;
    send_field(32'h31, 1, 256'h7A7A7A7A, 4, 1);
    wait_drain();
    chk_eq("after_reset_ck", last_ck, 8'h57);

    // randomized fields with random backpressure
    bp_mode = 2;
    for (int f = 0; f < 40; f++) begin
      rtag = '0; rval = '0;
      for (int k = 0; k < TB; k++) rtag[8*k +: 8] = 8'($urandom_range(33, 126));
      for (int k = 0; k < VB; k++) rval[8*k +: 8] = 8'($urandom_range(32, 126));
      tl  = $urandom_range(1, TB);
      vl  = $urandom_range(0, VB);
      lst = ($urandom_range(0, 9) < 3) || (f == 39);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) tl = $urandom_range(0, 1) ? 0 : $urandom_range(TB + 1, 7);
        else vl = $urandom_range(VB + 1, 63);
      end
      send_field(rtag, tl, rval, vl, lst);
    end
    wait_drain();
    bp_mode = 0;
    repeat (4) @(negedge clk);
    chk_eq("final_queue_empty", q_data.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/fix_msg_serializer.md
# fix_msg_serializer

Parametrised FIX message serializer for the message-create path. It accepts one tag/value field per handshake and emits the bytes "tag=value<SOH>" one per cycle under ready/valid backpressure. It accumulates the FIX checksum internally. On the field marked last it appends the trailer "10=ddd<SOH>", where ddd is the checksum as three ASCII decimal digits. It sits between the field generator and the byte-stream transmit logic and replaces the external checksum handshake.

## Interface
- TAG_BYTES, default 4: maximum tag length in bytes.
- VAL_BYTES, default 32: maximum value length in bytes.
- SOH, default 8'h01: field delimiter byte.
- TL, default $clog2(TAG_BYTES+1): width of tag_len_i (localparam).
- VL, default $clog2(VAL_BYTES+1): width of val_len_i (localparam).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low. rst==0 at a posedge resets the block.
- field_valid_i  in  1  field present.
- field_ready_o  out  1  block can accept a field.
- tag_i  in  8*TAG_BYTES  tag ASCII bytes; byte k = tag_i[8k +: 8]; byte 0 is sent first.
- tag_len_i  in  TL  tag byte count; legal range 1..TAG_BYTES.
- val_i  in  8*VAL_BYTES  value ASCII bytes; byte 0 is sent first.
- val_len_i  in  VL  value byte count; legal range 0..VAL_BYTES.
- last_i  in  1  this field closes the message body; append the checksum trailer.
- data_o  out  8  output byte.
- data_valid_o  out  1  data_o is valid.
- data_ready_i  in  1  downstream accepts the byte.
- sof_o  out  1  qualifies data_o: first byte of a message.
- eom_o  out  1  qualifies data_o: final trailer SOH.
- chksum_o  out  8  checksum value; valid while eom_o=1.
- err_o  out  1  one-cycle pulse: illegal field dropped.

## Operation
- A field is accepted when field_valid_i && field_ready_o at a posedge. tag_i, val_i, both lengths and last_i are registered at acceptance.
- field_ready_o=1 only in state IDLE.
- Illegal field: tag_len_i==0, tag_len_i>TAG_BYTES or val_len_i>VAL_BYTES.
  - The field is consumed and err_o pulses in the next cycle.
  - No bytes are emitted and the checksum is unchanged.
  - last_i on an illegal field is ignored.
  - The block stays in IDLE.
- States, in emission order:
  - IDLE.
  - TAG: bytes 0..tag_len-1.
  - EQ: 8'h3D.
  - VAL: bytes 0..val_len-1; skipped when val_len==0.
  - FSOH: SOH.
  - If last, after FSOH: T1 '1'(31), T0 '0'(30), TEQ '='(3D), D2, D1, D0, TSOH (SOH).
  - Then IDLE.
- A state advances only on a byte transfer (data_valid_o && data_ready_i). Byte index counters increment per transfer.
- Checksum:
  - 8-bit accumulator; each transferred byte from TAG through FSOH is added mod 256, wrap-around intended.
  - Trailer bytes are not added.
  - The accumulator clears after the TSOH transfer.
- Digit latch:
  - On entry to T1 the block latches ck = accumulator.
  - D2 = 8'h30 + ck/100, D1 = 8'h30 + (ck/10)%10, D0 = 8'h30 + ck%10.
  - chksum_o = ck.
- sof_o=1 on the first TAG byte after reset or after an eom_o transfer.
- eom_o=1 on the TSOH byte only.
- Output hold: while data_valid_o=1 and data_ready_i=0, the values of data_o, sof_o, eom_o and chksum_o stay stable.

## Timing
- Reset values: field_ready_o=0 in the reset cycle and 1 from the first cycle after. data_o=0, data_valid_o=0, sof_o=0, eom_o=0, chksum_o=0, err_o=0.
- Reset clears the state, counters, checksum and the in-message flag.
- Latency: field accepted at edge N gives first byte valid in cycle N+1. With data_ready_i held 1, throughput is 1 byte/cycle.
- A non-last field occupies T+V+2 transfer cycles. field_ready_o rises in the cycle after the FSOH transfer (one bubble between fields).
- A last field adds 7 trailer cycles. field_ready_o rises in the cycle after the TSOH transfer.
- Outputs are registered; there is no combinational path from data_ready_i to data_o.
- Reset mid-message:
  - The partial output is abandoned with no trailer.
  - The next accepted field starts a new message with sof_o=1.
- With field_valid_i held 1 during emission, nothing is accepted until IDLE.

## Test plan
- Single last field, tag "35" (tag_i[15:0]=16'h3533, len 2), val "A" (8'h41, len 1), ready=1:
  - bytes 33 35 3D 41 01 31 30 3D 32 33 31 01 on consecutive cycles.
  - sof_o on the first byte; eom_o with chksum_o=8'hE7 (231) on the last.
- Wrap-around: tag "1" (len 1), val "zzzz" (len 4), last. Sum 599 mod 256 = 87 → digits 30 38 37, chksum_o=8'h57.
- Backpressure: same stimulus as the first scenario with data_ready_i toggling 1,0,0,1,…
  - The byte sequence is identical and data_o is stable while stalled.
  - The total cycle count equals the number of ready-high cycles plus stall cycles.
- Two fields, the first non-last and the second last:
  - sof_o only on the first byte.
  - The checksum covers both fields' bytes.
  - field_ready_o stays low until the cycle after the first FSOH transfer.
- Illegal fields (tag_len=0; then val_len=VAL_BYTES+1):
  - err_o pulses once each and no data_valid_o.
  - A following legal last field gives a checksum equal to that field alone.
- Reset mid-value: assert rst=0 for one edge during the VAL bytes of a 10-byte value.
  - All outputs return to reset values the next cycle.
  - The next field's first byte has sof_o=1 and its checksum excludes the aborted bytes.
